// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer with press/release edge pulses.
//
// Purpose:
//   Each channel synchronises a raw asynchronous button level. The channel
//   accepts a new level only after it has held for DEBOUNCE_CYCLES clocks.
//   The accepted level drives o_button. One-cycle pulses mark each accepted
//   0->1 change (o_press) and, optionally, each 1->0 change (o_release).
//
// Parameters:
//   NB_BUTTON       number of independent button channels
//   NB_DEBOUNCE     stability counter width per channel, in bits
//   DEBOUNCE_CYCLES cycles a new level must hold (legal range 2..2**NB_DEBOUNCE)
//
// Ports:
//   clock      system clock, rising edge
//   i_reset    synchronous, active-high reset
//   i_button   raw button levels, 1 = pressed
//   o_button   debounced level per channel
//   o_press    one-cycle pulse on a debounced 0->1 change
//   o_release  one-cycle pulse on a debounced 1->0 change
//
// Configuration macro:
//   BUTTON_DEBOUNCER_RELEASE_EN  when defined, the release-edge pulse logic
//                                is built. Otherwise o_release is tied to 0.

module button_debouncer #(
    parameter int NB_BUTTON       = 4,
    parameter int NB_DEBOUNCE     = 20,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic [NB_BUTTON-1:0] i_button,
    output logic [NB_BUTTON-1:0] o_button,
    output logic [NB_BUTTON-1:0] o_press,
    output logic [NB_BUTTON-1:0] o_release
);

    // The counter runs 0..DEBOUNCE_CYCLES-1 and never wraps. The top value
    // fits in NB_DEBOUNCE bits even when DEBOUNCE_CYCLES == 2**NB_DEBOUNCE.
    localparam logic [NB_DEBOUNCE-1:0] CNT_LAST =
        NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 ||
        longint'(DEBOUNCE_CYCLES) > (longint'(1) << NB_DEBOUNCE))
    begin : g_illegal_cfg
        $error("button_debouncer: DEBOUNCE_CYCLES out of range");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NB_BUTTON-1:0]   sync1_q, sync1_d;
    logic [NB_BUTTON-1:0]   sync2_q, sync2_d;
    logic [NB_BUTTON-1:0]   stable_q, stable_d;
    logic [NB_BUTTON-1:0]   press_q, press_d;
    logic [NB_DEBOUNCE-1:0] cnt_q [NB_BUTTON];
    logic [NB_DEBOUNCE-1:0] cnt_d [NB_BUTTON];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d  = i_button;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;

        for (int i = 0; i < NB_BUTTON; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                // Level agrees with the accepted state; any partial
                // count from a glitch is discarded.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // Held long enough: accept the new level.
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + NB_DEBOUNCE'(1);
            end
        end

        // The pulse registers on the same edge that updates the stable
        // state, so a pulse lines up with the first cycle of the new
        // o_button level.
        press_d = stable_d & ~stable_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (i_reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            press_q  <= '0;
            cnt_q    <= '{default: '0};
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_button = stable_q;
    assign o_press  = press_q;

    // ------------------------------------------------------------------
    // Optional release-edge pulse
    // ------------------------------------------------------------------
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
    logic [NB_BUTTON-1:0] release_q, release_d;

    always_comb begin
        release_d = stable_q & ~stable_d;
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            release_q <= '0;
        end else begin
            release_q <= release_d;
        end
    end

    assign o_release = release_q;
`else
    assign o_release = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (4 channels, 4-cycle debounce).
// Reference model: a level is accepted once D consecutive synced samples oppose it.

module tb_button_debouncer;

    localparam int NB  = 4;
    localparam int NBD = 2;
    localparam int D   = 4;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [NB-1:0] i_button = '0;
    logic [NB-1:0] o_button;
    logic [NB-1:0] o_press;
    logic [NB-1:0] o_release;

    always #5 clk = ~clk;

    button_debouncer #(
        .NB_BUTTON      (NB),
        .NB_DEBOUNCE    (NBD),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock    (clk),
        .i_reset  (i_reset),
        .i_button (i_button),
        .o_button (o_button),
        .o_press  (o_press),
        .o_release(o_release)
    );

    typedef struct {
        int            e;
        logic [NB-1:0] btn;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    req;
    } dir_t;

    exp_t exp_q[$];
    dir_t dir_q[$];

    int checks = 0;
    int errors = 0;
    int n_edge = 0;

    int press_cnt  [NB] = '{default: 0};
    int rel_cnt    [NB] = '{default: 0};
    int last_press [NB] = '{default: -1};
    int last_rel   [NB] = '{default: -1};

    // ------------------------------------------------------------------
    // Reference model: history of raw samples, newest at the back.
    // After pushing the sample of edge e, entries 0..D-1 are the samples
    // of edges e-D-1..e-2, i.e. what the second sync stage showed over
    // the last D edges.
    // ------------------------------------------------------------------
    logic [NB-1:0] hist[$];
    logic [NB-1:0] m_stable = '0;

    function automatic void model_step(input logic [NB-1:0] b,
                                       input logic r,
                                       output exp_t x);
        logic [NB-1:0] h;
        bit            all;
        x.e   = n_edge;
        x.prs = '0;
        x.rel = '0;
        if (r) begin
            hist.delete();
            for (int j = 0; j < D + 2; j++) hist.push_back('0);
            m_stable = '0;
        end else begin
            hist.push_back(b);
            if (hist.size() > D + 2) void'(hist.pop_front());
            for (int c = 0; c < NB; c++) begin
                all = 1'b1;
                for (int j = 0; j < D; j++) begin
                    h = hist[j];
                    if (h[c] == m_stable[c]) all = 1'b0;
                end
                if (all) begin
                    m_stable[c] = ~m_stable[c];
                    if (m_stable[c]) begin
                        x.prs[c] = 1'b1;
                    end else begin
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
                        x.rel[c] = 1'b1;
`endif
                    end
                end
            end
        end
        x.btn = m_stable;
    endfunction

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic step(input logic [NB-1:0] b, input logic r);
        exp_t x;
        @(negedge clk);
        i_button = b;
        i_reset  = r;
        model_step(b, r, x);
        exp_q.push_back(x);
        n_edge++;
    endtask

    task automatic dcheck(input string name, input int act, input int req);
        dir_t d;
        d.name = name;
        d.act  = act;
        d.req  = req;
        dir_q.push_back(d);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || dir_q.size() != 0) && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0 || dir_q.size() != 0) begin
            $display("FAIL drain: %0d entries left, required 0",
                     exp_q.size() + dir_q.size());
            $fatal(1);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops one expectation per edge and any directed checks
    // ------------------------------------------------------------------
    exp_t mx;
    dir_t md;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mx = exp_q.pop_front();
            checks++;
            if (o_button !== mx.btn || o_press !== mx.prs ||
                o_release !== mx.rel) begin
                errors++;
                $display("FAIL outputs edge %0d: got btn=%b press=%b rel=%b, required btn=%b press=%b rel=%b",
                         mx.e, o_button, o_press, o_release,
                         mx.btn, mx.prs, mx.rel);
            end
            for (int c = 0; c < NB; c++) begin
                if (o_press[c] === 1'b1) begin
                    press_cnt[c]++;
                    last_press[c] = mx.e;
                end
                if (o_release[c] === 1'b1) begin
                    rel_cnt[c]++;
                    last_rel[c] = mx.e;
                end
            end
        end
        while (dir_q.size() != 0) begin
            md = dir_q.pop_front();
            checks++;
            if (md.act != md.req) begin
                errors++;
                $display("FAIL %s: got %0d, required %0d",
                         md.name, md.act, md.req);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int            base;
        int            p0;
        int            p1;
        int            p3;
        int            r0;
        int            rtot;
        logic [NB-1:0] lvl;
        logic          rst;

        step('0, 1'b1);
        step('0, 1'b1);
        repeat (8) step('0, 1'b0);

        // Single press on channel 0, held.
        drain();
        p0   = press_cnt[0];
        base = n_edge;
        repeat (12) step(4'b0001, 1'b0);
        drain();
        dcheck("press0_edge", last_press[0], base + 5);
        dcheck("press0_count", press_cnt[0] - p0, 1);

        // Release of channel 0.
        r0   = rel_cnt[0];
        rtot = rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3];
        base = n_edge;
        repeat (12) step(4'b0000, 1'b0);
        drain();
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
        dcheck("release0_edge", last_rel[0], base + 5);
        dcheck("release0_count", rel_cnt[0] - r0, 1);
`else
        dcheck("release_total",
               rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] - rtot, 0);
        dcheck("release0_count", rel_cnt[0] - r0, 0);
`endif

        // Three-cycle glitch on channel 1.
        p1 = press_cnt[1];
        repeat (3) step(4'b0010, 1'b0);
        repeat (10) step(4'b0000, 1'b0);
        drain();
        dcheck("glitch1_press", press_cnt[1] - p1, 0);

        // Two channels together.
        p1   = press_cnt[1];
        p3   = press_cnt[3];
        base = n_edge;
        repeat (12) step(4'b1010, 1'b0);
        drain();
        dcheck("press1_edge", last_press[1], base + 5);
        dcheck("press3_edge", last_press[3], base + 5);
        dcheck("press1_count", press_cnt[1] - p1, 1);
        dcheck("press3_count", press_cnt[3] - p3, 1);
        repeat (12) step(4'b0000, 1'b0);

        // Reset mid-count, button still held.
        drain();
        p0   = press_cnt[0];
        base = n_edge;
        repeat (4) step(4'b0001, 1'b0);
        step(4'b0001, 1'b1);
        repeat (12) step(4'b0001, 1'b0);
        drain();
        dcheck("rst_press0_edge", last_press[0], base + 10);
        dcheck("rst_press0_count", press_cnt[0] - p0, 1);
        repeat (12) step(4'b0000, 1'b0);

        // Long hold: no auto-repeat.
        drain();
        p0 = press_cnt[2];
        repeat (1000) step(4'b0100, 1'b0);
        drain();
        dcheck("hold2_count", press_cnt[2] - p0, 1);
        repeat (12) step(4'b0000, 1'b0);

        // Randomised levels with occasional reset.
        lvl = '0;
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(0, 5) == 0) lvl[c] = ~lvl[c];
            end
            rst = ($urandom_range(0, 299) == 0);
            step(lvl, rst);
        end

        drain();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
